mac_seq_ctrl: RTL
=================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL expose parameter INP_WIDTH, default 8, signed input operand width.
REQ-002 SHALL expose parameter WGT_WIDTH, default 8, signed weight operand width.
REQ-003 SHALL expose parameter ACC_WIDTH, default 32, accumulator/result width.
REQ-004 SHALL expose parameter LEN_WIDTH, default 16, dot-product length field width.
REQ-005 SHALL expose parameter ADDR_WIDTH, default 12, operand buffer address width.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 start  in  1  command strobe; sampled only in IDLE.
REQ-009 len  in  LEN_WIDTH  number of products N; 0 allowed.
REQ-010 inp_base / wgt_base  in  ADDR_WIDTH each  first operand addresses.
REQ-011 acc_init  in  ACC_WIDTH  initial accumulator value.
REQ-012 rd_en  out  1  operand buffer read strobe.
REQ-013 inp_addr / wgt_addr  out  ADDR_WIDTH each  read addresses.
REQ-014 inp_data / wgt_data  in  INP_WIDTH / WGT_WIDTH  read data, valid exactly 1 cycle after rd_en.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  consumer accepts result.
REQ-018 res_data  out  ACC_WIDTH  accumulated result.
REQ-019 done  out  1  one-cycle pulse on result handshake.

Function
REQ-020 SHALL implement states IDLE, ISSUE, DRAIN, OUT.
REQ-021 IDLE & start & len!=0: latch len, bases; acc <= acc_init; idx <= 0; go ISSUE.
REQ-022 IDLE & start & len==0: acc <= acc_init; go OUT directly; no rd_en issued.
REQ-023 ISSUE: rd_en=1, inp_addr=inp_base+idx, wgt_addr=wgt_base+idx; idx++ each cycle; after N issue cycles go DRAIN.
REQ-024 Addresses SHALL wrap modulo 2^ADDR_WIDTH.
REQ-025 Each cycle following an rd_en: acc <= acc + sext(inp_data)*sext(wgt_data), truncated to ACC_WIDTH (two's-complement wrap, no saturation).
REQ-026 DRAIN: rd_en=0, final product accumulated; go OUT next cycle.
REQ-027 OUT: res_valid=1, res_data=acc held stable until res_valid&res_ready.
REQ-028 On handshake: done=1 that cycle, next state IDLE, res_valid deasserts next cycle.
REQ-029 Latency: start in cycle T, len=N>=1 -> res_valid first high in cycle T+N+2; len=0 -> T+1.
REQ-030 start outside IDLE SHALL be ignored (no latch, no effect on running operation).
REQ-031 rd_en, inp_addr, wgt_addr SHALL be 0 whenever not in ISSUE.
REQ-032 res_data SHALL be 0 whenever res_valid is low.
REQ-033 len, bases and acc_init SHALL be sampled only at accepted start; later changes do not affect the operation.

Reset
REQ-034 rst_n low at any clock edge, including mid-operation, SHALL force IDLE, acc=0, idx=0.
REQ-035 During and after reset, until next start: rd_en=0, addresses=0, busy=0, res_valid=0, res_data=0, done=0.
REQ-036 An operation interrupted by reset SHALL produce no result or done pulse.

Verification
REQ-037 len=4, bases 0, inp={1,2,3,4}, wgt={5,6,7,8}, acc_init=10, res_ready=1 -> rd_en cycles T+1..T+4, res_data=80 at T+6, done same cycle.
REQ-038 len=1, inp=0xFF, wgt=0x02, acc_init=0 -> res_data=0xFFFFFFFE (signed -2).
REQ-039 len=0, acc_init=0x1234 -> res_valid at T+1, res_data=0x1234, no rd_en.
REQ-040 len=1, acc_init=0x7FFFFFFF, inp=1, wgt=1 -> res_data=0x80000000 (wrap); inp_base=0xFFF, len=2 -> inp_addr 0xFFF then 0x000.
REQ-041 res_ready held low 5 cycles in OUT, start pulsed during busy -> res_data stable, start ignored, done only on handshake cycle.
REQ-042 rst_n low during ISSUE of len=8 -> next cycle IDLE, all outputs 0; subsequent len=1 command completes normally.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
//
// Sequences one signed dot product over an external operand buffer.
// It loads an initial accumulator value and issues N reads. Each returned
// pair of operands is multiplied and added to the accumulator. The final
// value is then presented on a valid/ready result port.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   start      : command strobe, only looked at while idle
//   len        : number of products N (0 gives acc_init straight back)
//   inp_base   : first input-operand address
//   wgt_base   : first weight-operand address
//   acc_init   : initial accumulator value
//   rd_en      : operand buffer read strobe
//   inp_addr   : input-operand read address
//   wgt_addr   : weight-operand read address
//   inp_data   : input-operand read data, one cycle after rd_en
//   wgt_data   : weight-operand read data, one cycle after rd_en
//   busy       : high whenever a command is in progress
//   res_valid  : result available
//   res_ready  : consumer accepts the result
//   res_data   : accumulated result, zero while res_valid is low
//   done       : one-cycle pulse on the result handshake
// -----------------------------------------------------------------------------
module mac_seq_ctrl #(
    parameter int INP_WIDTH  = 8,
    parameter int WGT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [ADDR_WIDTH-1:0] inp_base,
    input  logic [ADDR_WIDTH-1:0] wgt_base,
    input  logic [ACC_WIDTH-1:0]  acc_init,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] inp_addr,
    output logic [ADDR_WIDTH-1:0] wgt_addr,
    input  logic [INP_WIDTH-1:0]  inp_data,
    input  logic [WGT_WIDTH-1:0]  wgt_data,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ACC_WIDTH-1:0]  ACC_ZERO  = {ACC_WIDTH{1'b0}};

    // Sign-extended product of one operand pair.
    // It is truncated to the accumulator width, so the sum wraps in two's complement.
    function automatic logic [ACC_WIDTH-1:0] mac_term(
        input logic [INP_WIDTH-1:0] a,
        input logic [WGT_WIDTH-1:0] b
    );
        logic signed [INP_WIDTH+WGT_WIDTH-1:0] prod;
        prod = $signed(a) * $signed(b);
        return ACC_WIDTH'(prod);
    endfunction

    logic [1:0]            state_r,     state_nx_s;
    logic [LEN_WIDTH-1:0]  len_r,       len_nx_s;
    logic [LEN_WIDTH-1:0]  idx_r,       idx_nx_s;
    logic [ACC_WIDTH-1:0]  acc_r,       acc_nx_s;
    logic                  pend_r;
    logic                  rd_en_r,     rd_en_nx_s;
    logic [ADDR_WIDTH-1:0] inp_addr_r,  inp_addr_nx_s;
    logic [ADDR_WIDTH-1:0] wgt_addr_r,  wgt_addr_nx_s;
    logic                  busy_r,      busy_nx_s;
    logic                  res_valid_r, res_valid_nx_s;
    logic [ACC_WIDTH-1:0]  res_data_r,  res_data_nx_s;

    // Next-state, accumulator and registered-output decode.
    // The address registers double as the read pointers while in ISSUE.
    always_comb begin
        state_nx_s    = state_r;
        len_nx_s      = len_r;
        idx_nx_s      = idx_r;
        inp_addr_nx_s = ADDR_ZERO;
        wgt_addr_nx_s = ADDR_ZERO;

        // pend_r marks the cycle in which read data from the previous rd_en is present.
        if (pend_r) begin
            acc_nx_s = acc_r + mac_term(inp_data, wgt_data);
        end else begin
            acc_nx_s = acc_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    acc_nx_s = acc_init;
                    len_nx_s = len;
                    idx_nx_s = LEN_ZERO;
                    if (len == LEN_ZERO) begin
                        state_nx_s = ST_OUT;
                    end else begin
                        state_nx_s    = ST_ISSUE;
                        inp_addr_nx_s = inp_base;
                        wgt_addr_nx_s = wgt_base;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (idx_r == len_r - LEN_ONE) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s    = ST_ISSUE;
                    idx_nx_s      = idx_r + LEN_ONE;
                    inp_addr_nx_s = inp_addr_r + ADDR_ONE;
                    wgt_addr_nx_s = wgt_addr_r + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                state_nx_s = ST_OUT;
            end
            ST_OUT: begin
                if (res_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_OUT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        rd_en_nx_s     = (state_nx_s == ST_ISSUE);
        busy_nx_s      = (state_nx_s != ST_IDLE);
        res_valid_nx_s = (state_nx_s == ST_OUT);
        if (res_valid_nx_s) begin
            res_data_nx_s = acc_nx_s;
        end else begin
            res_data_nx_s = ACC_ZERO;
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            len_r       <= LEN_ZERO;
            idx_r       <= LEN_ZERO;
            acc_r       <= ACC_ZERO;
            pend_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            inp_addr_r  <= ADDR_ZERO;
            wgt_addr_r  <= ADDR_ZERO;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= ACC_ZERO;
        end else begin
            state_r     <= state_nx_s;
            len_r       <= len_nx_s;
            idx_r       <= idx_nx_s;
            acc_r       <= acc_nx_s;
            pend_r      <= rd_en_r;
            rd_en_r     <= rd_en_nx_s;
            inp_addr_r  <= inp_addr_nx_s;
            wgt_addr_r  <= wgt_addr_nx_s;
            busy_r      <= busy_nx_s;
            res_valid_r <= res_valid_nx_s;
            res_data_r  <= res_data_nx_s;
        end
    end

    assign rd_en     = rd_en_r;
    assign inp_addr  = inp_addr_r;
    assign wgt_addr  = wgt_addr_r;
    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    // done marks the handshake cycle itself, so it must follow res_ready combinationally.
    assign done      = res_valid_r & res_ready;

endmodule
